sqrt_arb_m: RTL and testbench

//  Shares one sqrt_m integer square-root core between N requesters.

---
 rtl/sqrt_arb_pkg.sv | 15 +
 rtl/sqrt_arb_rr_arbiter.sv | 35 +++
 rtl/sqrt_arb_m.sv | 91 +++++++++
 tb/tb_sqrt_arb_m.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared types for the sqrt_m sharing controller: FSM state encoding and default widths.
package sqrt_arb_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_N  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  typedef logic [DEF_DW-1:0] data_t;

endpackage

// File: rtl/sqrt_arb_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping N-1 -> 0.
module rr_arbiter_m #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int          idx;
  logic        found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so one subtraction is enough to wrap
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/sqrt_arb_m.sv
// Shares one sqrt_m core between N requesters with round-robin arbitration.
// Handshake: a request is accepted in the cycle where req_valid[i] & req_ready[i] is high.
module sqrt_arb_m
  import sqrt_arb_pkg::*;
#(
  parameter  int DW = 8,
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N-1:0][DW-1:0] req_data,
  output logic [N-1:0]         rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 sqrt_start,
  input  logic                 sqrt_ready,
  output logic [DW-1:0]        sqrt_r,
  input  logic [DW-1:0]        sqrt_q,
  output state_t               dbg_state,
  output logic [IW-1:0]        dbg_ptr
);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          accept;

  rr_arbiter_m #(.N(N)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are only offered while the core is idle and no job is in flight.
  assign req_ready = (state == IDLE && sqrt_ready) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = START;
      START:   if (!sqrt_ready) state_nxt = BUSY;
      BUSY:    if (sqrt_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      sqrt_start <= 1'b0;
      sqrt_r     <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            sqrt_r     <= req_data[gnt_idx];
            id         <= gnt_idx;
            sqrt_start <= 1'b1;
          end
        end
        START: begin
          // Core drops ready once it has taken the operand.
          if (!sqrt_ready) sqrt_start <= 1'b0;
        end
        BUSY: begin
          if (sqrt_ready) begin
            rsp_data      <= sqrt_q;
            rsp_valid[id] <= 1'b1;
            ptr           <= (id == IW'(N - 1)) ? '0 : id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arb_m.sv
// Bench for sqrt_arb_m with a behavioural sqrt_m core of random latency and a response scoreboard.
module tb_sqrt_arb_m;
  import sqrt_arb_pkg::*;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][DW-1:0] req_data = '0;
  logic [N-1:0]         rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 sqrt_start;
  logic                 sqrt_ready;
  logic [DW-1:0]        sqrt_r;
  logic [DW-1:0]        sqrt_q;
  state_t               dbg_state;
  logic [IW-1:0]        dbg_ptr;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  int jobs_left [N];

  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] exp_id_q[$];

  always #5 clk = ~clk;

  sqrt_arb_m #(.DW(DW), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .sqrt_start (sqrt_start),
    .sqrt_ready (sqrt_ready),
    .sqrt_r     (sqrt_r),
    .sqrt_q     (sqrt_q),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  // Behavioural sqrt_m: takes r when start & ready, drops ready, answers after 1..4 cycles.
  logic [DW-1:0] core_r;
  int            core_cnt;

  function automatic logic [DW-1:0] core_isqrt(input logic [DW-1:0] x);
    logic [DW-1:0] root, trial;
    root = '0;
    for (int b = DW / 2 - 1; b >= 0; b--) begin
      trial = root | (DW'(1) << b);
      if (int'(trial) * int'(trial) <= int'(x)) root = trial;
    end
    return root;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sqrt_ready <= 1'b1;
      sqrt_q     <= '0;
      core_cnt   <= 0;
      core_r     <= '0;
    end else if (sqrt_ready) begin
      if (sqrt_start) begin
        sqrt_ready <= 1'b0;
        core_r     <= sqrt_r;
        core_cnt   <= int'($urandom_range(0, 3));
      end
    end else if (core_cnt == 0) begin
      sqrt_ready <= 1'b1;
      sqrt_q     <= core_isqrt(core_r);
    end else begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Reference: largest k with k*k <= x, by linear search.
  function automatic logic [DW-1:0] ref_sqrt(input int x);
    int k;
    k = 0;
    while ((k + 1) * (k + 1) <= x) k++;
    return DW'(k);
  endfunction

  task automatic push_exp(input int id, input int val);
    exp_id_q.push_back(IW'(id));
    exp_q.push_back(DW'(val));
  endtask

  task automatic issue(input int id, input int data, input int jobs);
    req_valid[id] = 1'b1;
    req_data[id]  = DW'(data);
    jobs_left[id] = jobs;
  endtask

  // One clock: check grants and responses at negedge, then retire accepted requests.
  task automatic step();
    logic [N-1:0]  acc;
    logic [IW-1:0] eid;
    logic [DW-1:0] ev;
    logic [N-1:0]  eonehot;
    @(negedge clk);
    acc = req_valid & req_ready;
    n_vec++;
    if (!$onehot0(req_ready) || ((dbg_state != IDLE || !sqrt_ready) && req_ready !== '0)) begin
      n_err++;
      $display("FAIL grant: req_ready=%b state=%0d sqrt_ready=%b, required one-hot only in IDLE with core ready",
               req_ready, dbg_state, sqrt_ready);
    end
    if (|rsp_valid) begin
      n_rsp++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: rsp_valid=%b rsp_data=%0d, required no response", rsp_valid, rsp_data);
      end else begin
        eid = exp_id_q.pop_front();
        ev  = exp_q.pop_front();
        eonehot = '0;
        eonehot[eid] = 1'b1;
        if (rsp_valid !== eonehot || rsp_data !== ev) begin
          n_err++;
          $display("FAIL rsp: rsp_valid=%b rsp_data=%0d, required rsp_valid=%b rsp_data=%0d",
                   rsp_valid, rsp_data, eonehot, ev);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (jobs_left[i] > 1) jobs_left[i]--;
        else begin
          jobs_left[i] = 0;
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done(input string name, input int k, input int budget);
    int base, c;
    base = n_rsp;
    c = 0;
    while (n_rsp - base < k && c < budget) begin
      step();
      c++;
    end
    n_vec++;
    if (n_rsp - base < k || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_done: responses=%0d pending=%0d, required responses=%0d pending=0",
               name, n_rsp - base, exp_q.size(), k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) jobs_left[i] = 0;
    exp_q.delete();
    exp_id_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || sqrt_start !== 1'b0 ||
        sqrt_r !== '0 || dbg_state !== IDLE || dbg_ptr !== '0) begin
      n_err++;
      $display("FAIL %s: req_ready=%b rsp_valid=%b rsp_data=%0d start=%b r=%0d state=%0d ptr=%0d, required all zero/IDLE",
               name, req_ready, rsp_valid, rsp_data, sqrt_start, sqrt_r, dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    issue(0, 49, 1);
    push_exp(0, 7);
    wait_done("single", 1, 40);
  endtask

  task automatic test_all_four();
    do_reset();
    issue(0, 16, 1);
    issue(1, 25, 1);
    issue(2, 36, 1);
    issue(3, 255, 1);
    push_exp(0, 4);
    push_exp(1, 5);
    push_exp(2, 6);
    push_exp(3, 15);
    wait_done("all_four", 4, 120);
  endtask

  task automatic test_alternate();
    do_reset();
    issue(0, 100, 2);
    issue(2, 9, 2);
    push_exp(0, 10);
    push_exp(2, 3);
    push_exp(0, 10);
    push_exp(2, 3);
    wait_done("alternate", 4, 120);
  endtask

  task automatic test_wrap();
    do_reset();
    issue(3, 64, 1);
    push_exp(3, 8);
    wait_done("wrap_first", 1, 40);
    n_vec++;
    if (dbg_ptr !== '0) begin
      n_err++;
      $display("FAIL wrap_ptr: ptr=%0d, required 0", dbg_ptr);
    end
    issue(0, 1, 1);
    issue(3, 2, 1);
    push_exp(0, 1);
    push_exp(3, 1);
    wait_done("wrap", 2, 80);
  endtask

  task automatic test_sweep();
    do_reset();
    for (int x = 0; x < 256; x++) begin
      issue(1, x, 1);
      push_exp(1, int'(ref_sqrt(x)));
      wait_done("sweep", 1, 40);
    end
  endtask

  task automatic test_reset_busy();
    bit hit;
    do_reset();
    issue(1, 200, 1);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      step();
      if (dbg_state == BUSY) hit = 1'b1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_busy: state=%0d, required BUSY within 40 cycles", dbg_state);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset_busy");
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) step();
    issue(3, 144, 1);
    push_exp(3, 12);
    wait_done("after_reset", 1, 40);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_wrap();
    test_sweep();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
